// File: rtl/apb_param_regfile_slave.sv
// APB4 completer over a parametrised register file with wait states, byte strobes,
// read-only masking and PSLVERR. Optional PPROT privilege check: APB_PPROT_CHECK_EN.
module apb_param_regfile_slave #(
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         ADDR_W      = 8,
    parameter int unsigned         NUM_REGS    = 16,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSELx,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    input  logic [2:0]          PPROT,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - LSB;

    typedef enum logic {StIdle, StAccess} state_e;

    state_e              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

`ifdef APB_PPROT_CHECK_EN
    logic priv_q, priv_d;
    logic unused_prot_hi;
    assign unused_prot_hi = ^PPROT[2:1];
`else
    logic unused_pprot;
    assign unused_pprot = ^PPROT;
`endif

    logic [IDX_W-1:0]  idx;
    logic              idx_oob, misaligned, ro_hit, err, ready;
    logic [DATA_W-1:0] rd_sel;

    assign idx = addr_q[ADDR_W-1:LSB];

    always_comb begin
        idx_oob    = (32'(idx) >= NUM_REGS);
        misaligned = |addr_q[LSB-1:0];
        ro_hit     = 1'b0;
        rd_sel     = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == i) begin
                ro_hit = RO_MASK[i];
                rd_sel = regs_q[i];
            end
        end
        err = idx_oob | misaligned | (write_q & ro_hit);
`ifdef APB_PPROT_CHECK_EN
        // Unprivileged access to any writable register is refused; RO reads stay legal.
        err = err | (~priv_q & ~ro_hit);
`endif
    end

    assign ready   = (state_q == StAccess) & PSELx & PENABLE & (wait_cnt_q == 4'(WAIT_STATES));
    assign PREADY  = ready;
    assign PSLVERR = ready & err;
    assign PRDATA  = (ready & ~err & ~write_q) ? rd_sel : '0;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
`ifdef APB_PPROT_CHECK_EN
        priv_d     = priv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (PSELx && !PENABLE) begin
                    state_d    = StAccess;
                    wait_cnt_d = '0;
                    addr_d     = PADDR;
                    write_d    = PWRITE;
                    wdata_d    = PWDATA;
                    strb_d     = PSTRB;
`ifdef APB_PPROT_CHECK_EN
                    priv_d     = PPROT[0];
`endif
                end
            end
            StAccess: begin
                if (!PSELx) begin
                    state_d = StIdle;
                end else if (!PENABLE) begin
                    wait_cnt_d = '0;
                    addr_d     = PADDR;
                    write_d    = PWRITE;
                    wdata_d    = PWDATA;
                    strb_d     = PSTRB;
`ifdef APB_PPROT_CHECK_EN
                    priv_d     = PPROT[0];
`endif
                end else if (ready) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (ready && !err && write_q) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(idx) == i) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (strb_q[b]) begin
                            regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
`ifdef APB_PPROT_CHECK_EN
            priv_q     <= 1'b0;
`endif
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
`ifdef APB_PPROT_CHECK_EN
            priv_q     <= priv_d;
`endif
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_param_regfile_slave.sv
// Directed bench: three completers share one APB bus with individual PSELx
// (0 wait states, 2 wait states with reg 1 read-only, 3 wait states).
module tb_apb_param_regfile_slave;

    logic        pclk;
    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        er;
    int          n;

    apb_param_regfile_slave #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(16), .WAIT_STATES(0),
        .RO_MASK(16'h0000), .RESET_VAL(32'h0000_0000)
    ) u_ws0 (
        .PCLK(pclk), .PRESET(preset), .PSELx(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_param_regfile_slave #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(16), .WAIT_STATES(2),
        .RO_MASK(16'h0002), .RESET_VAL(32'h0000_1234)
    ) u_ws2 (
        .PCLK(pclk), .PRESET(preset), .PSELx(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    apb_param_regfile_slave #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(16), .WAIT_STATES(3),
        .RO_MASK(16'h0000), .RESET_VAL(32'hCAFE_F00D)
    ) u_ws3 (
        .PCLK(pclk), .PRESET(preset), .PSELx(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transfer on completer s; n returns access cycles up to and including PREADY.
    task automatic xfer(input int s, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rdo, output logic erro, output int no);
        logic done;
        @(posedge pclk); #1;
        psel = '0; psel[s] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(negedge pclk);
        check("setup_pready", 32'(pready[s]), 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        no = 0; rdo = '0; erro = 1'b0; done = 1'b0;
        while (!done && no < 20) begin
            @(negedge pclk);
            no++;
            if (pready[s]) begin
                rdo = prdata[s]; erro = pslverr[s]; done = 1'b1;
            end
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
        repeat (2) @(negedge pclk);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata0", prdata[0], 32'd0);
        @(posedge pclk); #1;
        preset = 1'b0;

        // Zero-wait full write then read
        xfer(0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, rd, er, n);
        check("ws0_wr_cycles", 32'(n), 32'd1);
        check("ws0_wr_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, n);
        check("ws0_rd_cycles", 32'(n), 32'd1);
        check("ws0_rd_data", rd, 32'hDEAD_BEEF);
        check("ws0_rd_err", 32'(er), 32'd0);

        // Byte-strobe partial write
        xfer(0, 1'b1, 8'h04, 32'hAABB_CCDD, 4'hF, rd, er, n);
        xfer(0, 1'b1, 8'h04, 32'h1122_3344, 4'b0101, rd, er, n);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, rd, er, n);
        check("partial_data", rd, 32'hAA22_CC44);

        // Out-of-range and misaligned
        xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, rd, er, n);
        check("oob_err", 32'(er), 32'd1);
        check("oob_data", rd, 32'd0);
        xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, rd, er, n);
        check("misalign_err", 32'(er), 32'd1);
        check("misalign_data", rd, 32'd0);

        // Strobe-less write is a legal no-op
        xfer(0, 1'b1, 8'h08, 32'h0, 4'h0, rd, er, n);
        check("strb0_err", 32'(er), 32'd0);

        // Setup phase held for 10 cycles, then deselect
        @(posedge pclk); #1;
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08;
        pwdata = 32'h0; pstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            check("held_setup_pready", 32'(pready[0]), 32'd0);
        end
        @(posedge pclk); #1;
        psel = '0;

        // PENABLE without a setup phase
        @(posedge pclk); #1;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0;
        repeat (3) begin
            @(negedge pclk);
            check("noset_pready", 32'(pready[0]), 32'd0);
        end
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0;
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, n);
        check("after_hold_data", rd, 32'hDEAD_BEEF);

        // Two wait states and read-only register
        xfer(1, 1'b1, 8'h0C, 32'h0000_0055, 4'hF, rd, er, n);
        check("ws2_wr_cycles", 32'(n), 32'd3);
        check("ws2_wr_err", 32'(er), 32'd0);
        xfer(1, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, rd, er, n);
        check("ro_wr_err", 32'(er), 32'd1);
        xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, rd, er, n);
        check("ro_rd_data", rd, 32'h0000_1234);
        check("ro_rd_err", 32'(er), 32'd0);

        // Abort after one access cycle
        @(posedge pclk); #1;
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
        pwdata = 32'h0000_0099; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_pready", 32'(pready[1]), 32'd0);
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0;
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd, er, n);
        check("abort_data", rd, 32'h0000_0055);

`ifdef APB_PPROT_CHECK_EN
        pprot = 3'b000;
        xfer(0, 1'b1, 8'h0C, 32'h1234_5678, 4'hF, rd, er, n);
        check("pprot_err", 32'(er), 32'd1);
        pprot = 3'b001;
`endif

        // Three wait states, then reset mid-ACCESS
        xfer(2, 1'b1, 8'h08, 32'h1111_1111, 4'hF, rd, er, n);
        check("ws3_wr_cycles", 32'(n), 32'd4);
        xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, n);
        check("ws3_rd_data", rd, 32'h1111_1111);
        @(posedge pclk); #1;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08;
        pwdata = 32'h2222_2222; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        @(negedge pclk); #1;
        preset = 1'b1;
        #1;
        check("midrst_pready", 32'(pready[2]), 32'd0);
        check("midrst_prdata", prdata[2], 32'd0);
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0; preset = 1'b0;
        xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, n);
        check("midrst_reg2", rd, 32'hCAFE_F00D);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, n);
        check("rst_ws0_reg2", rd, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
